// File: rtl/axi4_mem_burst_ctrl_if.sv
// AXI4 slave-side bundle (AW/W/B/AR/R) for axi4_mem_burst_ctrl.
interface axi4_mem_burst_ctrl_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_mem_burst_ctrl.sv
// AXI4 slave that splits FIXED/INCR/WRAP bursts into single-beat memory accesses.
// Optional AXI_MEM_BOUNDARY_CHECK_EN: out-of-range / 4 KB-crossing bursts become SLVERR bursts.
module axi4_mem_burst_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned ID_WIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  axi4_mem_burst_ctrl_if.slave      s_axi,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);
  localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR_DATA = 2'd1;
  localparam logic [1:0] S_WR_RESP = 2'd2;
  localparam logic [1:0] S_RD_DATA = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]                r_state;
  logic [ID_WIDTH-1:0]       r_id;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                r_len;
  logic [1:0]                r_burst;
  logic [7:0]                r_cnt;
  logic                      r_err;
  logic                      r_werr;

  logic                      w_aw_hs;
  logic                      w_ar_hs;
  logic [ID_WIDTH-1:0]       w_req_id;
  logic [ADDR_WIDTH-1:0]     w_req_addr;
  logic [7:0]                w_req_len;
  logic [2:0]                w_req_size;
  logic [1:0]                w_req_burst;
  logic [MEM_ADDR_WIDTH-1:0] w_req_word;
  logic                      w_req_err;
  logic                      w_last;
  logic [MEM_ADDR_WIDTH-1:0] w_wrap_mask;
  logic [MEM_ADDR_WIDTH-1:0] w_next_addr;
  logic                      w_unused;

  assign w_aw_hs = !rst && (r_state == S_IDLE) && s_axi.awvalid;
  assign w_ar_hs = !rst && (r_state == S_IDLE) && s_axi.arvalid && !s_axi.awvalid;

  // Write request wins the shared request mux whenever AW is valid.
  assign w_req_id    = s_axi.awvalid ? s_axi.awid    : s_axi.arid;
  assign w_req_addr  = s_axi.awvalid ? s_axi.awaddr  : s_axi.araddr;
  assign w_req_len   = s_axi.awvalid ? s_axi.awlen   : s_axi.arlen;
  assign w_req_size  = s_axi.awvalid ? s_axi.awsize  : s_axi.arsize;
  assign w_req_burst = s_axi.awvalid ? s_axi.awburst : s_axi.arburst;
  assign w_req_word  = MEM_ADDR_WIDTH'(w_req_addr >> BYTE_SHIFT);
  assign w_unused    = ^{s_axi.awaddr, s_axi.araddr};

`ifdef AXI_MEM_BOUNDARY_CHECK_EN
  logic [31:0] w_first_word;
  logic [31:0] w_last_word;
  logic [31:0] w_page_end;

  // The whole burst footprint is known at request time, so the check is
  // resolved before the first beat and every beat of a bad burst is suppressed.
  always_comb begin
    w_first_word = 32'(w_req_addr >> BYTE_SHIFT);
    w_page_end   = 32'(w_req_addr[11:0]) + ((32'(w_req_len) + 32'd1) << BYTE_SHIFT);
    case (w_req_burst)
      BURST_FIXED: w_last_word = w_first_word;
      BURST_WRAP:  w_last_word = (w_first_word & ~32'(w_req_len)) + 32'(w_req_len);
      default:     w_last_word = w_first_word + 32'(w_req_len);
    endcase
    w_req_err = (w_req_burst == 2'b11) ||
                (w_req_size != 3'(BYTE_SHIFT)) ||
                ((w_req_burst == BURST_WRAP) && !(w_req_len == 8'd1 || w_req_len == 8'd3 ||
                                                  w_req_len == 8'd7 || w_req_len == 8'd15)) ||
                (w_last_word >= 32'(DEPTH)) ||
                ((w_req_burst == 2'b01) && (w_page_end > 32'd4096));
  end
`else
  always_comb begin
    w_req_err = (w_req_burst == 2'b11) ||
                (w_req_size != 3'(BYTE_SHIFT)) ||
                ((w_req_burst == BURST_WRAP) && !(w_req_len == 8'd1 || w_req_len == 8'd3 ||
                                                  w_req_len == 8'd7 || w_req_len == 8'd15));
  end
`endif

  assign w_last      = (r_cnt == r_len);
  assign w_wrap_mask = MEM_ADDR_WIDTH'(r_len[3:0]);

  always_comb begin
    case (r_burst)
      BURST_FIXED: w_next_addr = r_addr;
      BURST_WRAP:  w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + 1'b1) & w_wrap_mask);
      default:     w_next_addr = r_addr + 1'b1;
    endcase
  end

  always_comb begin
    s_axi.awready = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.bid     = '0;
    s_axi.bresp   = RESP_OKAY;
    s_axi.rvalid  = 1'b0;
    s_axi.rid     = '0;
    s_axi.rdata   = '0;
    s_axi.rresp   = RESP_OKAY;
    s_axi.rlast   = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          s_axi.awready = 1'b1;
          s_axi.arready = !s_axi.awvalid;
          if (w_ar_hs && !w_req_err) begin
            mem_en   = 1'b1;
            mem_addr = w_req_word;
          end
        end
        S_WR_DATA: begin
          s_axi.wready = 1'b1;
          if (s_axi.wvalid && !r_err) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_addr;
            mem_wdata = s_axi.wdata;
          end
        end
        S_WR_RESP: begin
          s_axi.bvalid = 1'b1;
          s_axi.bid    = r_id;
          s_axi.bresp  = (r_err || r_werr) ? RESP_SLVERR : RESP_OKAY;
        end
        default: begin
          s_axi.rvalid = 1'b1;
          s_axi.rid    = r_id;
          s_axi.rdata  = r_err ? '0 : mem_rdata;
          s_axi.rresp  = r_err ? RESP_SLVERR : RESP_OKAY;
          s_axi.rlast  = w_last;
          if (s_axi.rready && !w_last && !r_err) begin
            mem_en   = 1'b1;
            mem_addr = w_next_addr;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_werr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_hs || w_ar_hs) begin
            r_id    <= w_req_id;
            r_addr  <= w_req_word;
            r_len   <= w_req_len;
            r_burst <= w_req_burst;
            r_cnt   <= '0;
            r_err   <= w_req_err;
            r_werr  <= 1'b0;
            r_state <= w_aw_hs ? S_WR_DATA : S_RD_DATA;
          end
        end
        S_WR_DATA: begin
          if (s_axi.wvalid) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 8'd1;
            if (s_axi.wlast != w_last) r_werr <= 1'b1;
            if (w_last) r_state <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (s_axi.bready) r_state <= S_IDLE;
        end
        default: begin
          if (s_axi.rready) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_addr <= w_next_addr;
              r_cnt  <= r_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_mem_burst_ctrl.sv
// Scoreboard bench for axi4_mem_burst_ctrl: directed bursts push expectations, a negedge monitor checks.
module tb_axi4_mem_burst_ctrl;
  localparam int DW = 32, AW = 16, MAW = 10, DEPTH = 1024, IDW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_mem_burst_ctrl_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  logic           mem_en, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;
  logic [DW-1:0]  mem [DEPTH];

  axi4_mem_burst_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW), .DEPTH(DEPTH), .ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(axi),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: registered read data, held until the next read.
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  typedef struct packed { logic [MAW-1:0] addr; logic [DW-1:0] data; } mw_t;
  typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; logic last; logic [IDW-1:0] id; } r_t;
  typedef struct packed { logic [IDW-1:0] id; logic [1:0] resp; } b_t;

  mw_t exp_mw[$];
  r_t  exp_r[$];
  b_t  exp_b[$];
  int  checks = 0;
  int  failures = 0;
  bit  forbid_mem = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout required handshake", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en && mem_we) begin
        mw_t e;
        if (exp_mw.size() == 0) fail_now("mem_write_unexpected");
        else begin
          e = exp_mw.pop_front();
          chk("mem_write", {22'd0, mem_addr, mem_wdata}, {22'd0, e.addr, e.data});
        end
      end
      if (axi.rvalid && axi.rready) begin
        r_t e;
        if (exp_r.size() == 0) fail_now("r_beat_unexpected");
        else begin
          e = exp_r.pop_front();
          chk("r_beat", {25'd0, axi.rdata, axi.rresp, axi.rlast, axi.rid},
                        {25'd0, e.data, e.resp, e.last, e.id});
        end
      end
      if (axi.bvalid && axi.bready) begin
        b_t e;
        if (exp_b.size() == 0) fail_now("b_resp_unexpected");
        else begin
          e = exp_b.pop_front();
          chk("b_resp", {58'd0, axi.bid, axi.bresp}, {58'd0, e.id, e.resp});
        end
      end
      if (axi.rvalid && !axi.rready) chk("no_mem_while_r_stalled", 64'(mem_en), 64'd0);
      if (forbid_mem) chk("no_mem_in_error_burst", 64'(mem_en), 64'd0);
    end
  end

  task automatic push_mw(int a, int d);
    mw_t e; e.addr = MAW'(a); e.data = DW'(d); exp_mw.push_back(e);
  endtask
  task automatic push_r(int d, int resp, int last, int id);
    r_t e; e.data = DW'(d); e.resp = 2'(resp); e.last = 1'(last); e.id = IDW'(id); exp_r.push_back(e);
  endtask
  task automatic push_b(int id, int resp);
    b_t e; e.id = IDW'(id); e.resp = 2'(resp); exp_b.push_back(e);
  endtask

  // All stimulus tasks start and end at posedge+1.
  task automatic aw_hs(int id, int addr, int len, int size, int burst);
    bit hs = 1'b0;
    axi.awid = IDW'(id); axi.awaddr = AW'(addr); axi.awlen = 8'(len);
    axi.awsize = 3'(size); axi.awburst = 2'(burst); axi.awvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); if (axi.awready) hs = 1'b1;
      @(posedge clk); #1;
      if (hs) break;
    end
    axi.awvalid = 1'b0;
    if (!hs) fail_now("aw_handshake");
  endtask

  task automatic ar_hs(int id, int addr, int len, int size, int burst);
    bit hs = 1'b0;
    axi.arid = IDW'(id); axi.araddr = AW'(addr); axi.arlen = 8'(len);
    axi.arsize = 3'(size); axi.arburst = 2'(burst); axi.arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); if (axi.arready) hs = 1'b1;
      @(posedge clk); #1;
      if (hs) break;
    end
    axi.arvalid = 1'b0;
    if (!hs) fail_now("ar_handshake");
  endtask

  task automatic w_beats(int n, int base, int last_idx);
    for (int b = 0; b < n; b++) begin
      bit hs = 1'b0;
      axi.wdata = DW'(base + b); axi.wlast = (b == last_idx); axi.wvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); if (axi.wready) hs = 1'b1;
        @(posedge clk); #1;
        if (hs) break;
      end
      if (!hs) fail_now("w_handshake");
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
  endtask

  task automatic wait_b();
    bit hs = 1'b0;
    axi.bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) chk("b_latency", 64'(axi.bvalid), 64'd1);
      if (axi.bvalid) hs = 1'b1;
      @(posedge clk); #1;
      if (hs) break;
    end
    axi.bready = 1'b0;
    if (!hs) fail_now("b_handshake");
  endtask

  task automatic r_collect(bit bp);
    bit done = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      axi.rready = bp ? (cyc % 2 == 1) : 1'b1;
      @(negedge clk);
      if (cyc == 0) chk("r_latency", 64'(axi.rvalid), 64'd1);
      if (axi.rvalid && axi.rready && axi.rlast) done = 1'b1;
      @(posedge clk); #1;
      if (done) break;
    end
    axi.rready = 1'b0;
    if (!done) fail_now("r_last_handshake");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(axi.awready), 64'd0);
    chk("rst_arready", 64'(axi.arready), 64'd0);
    chk("rst_bvalid", 64'(axi.bvalid), 64'd0);
    chk("rst_rvalid", 64'(axi.rvalid), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", 64'(axi.awready), 64'd1);
    chk("post_rst_arready", 64'(axi.arready), 64'd1);
    @(posedge clk); #1;

    // INCR write, words 4..7
    for (int i = 0; i < 4; i++) push_mw(4 + i, 'hA0 + i);
    push_b(3, 0);
    aw_hs(3, 'h10, 3, 2, 1); w_beats(4, 'hA0, 3); wait_b();

    // INCR read with rready toggling
    for (int i = 0; i < 4; i++) push_r('hA0 + i, 0, i == 3, 5);
    ar_hs(5, 'h10, 3, 2, 1); r_collect(1'b1);

    // WRAP read from word 6: 6,7,4,5
    push_r('hA2, 0, 0, 6); push_r('hA3, 0, 0, 6); push_r('hA0, 0, 0, 6); push_r('hA1, 0, 1, 6);
    ar_hs(6, 'h18, 3, 2, 2); r_collect(1'b0);

    // FIXED write then FIXED read of word 8
    for (int i = 0; i < 3; i++) push_mw(8, 'hB0 + i);
    push_b(7, 0);
    aw_hs(7, 'h20, 2, 2, 0); w_beats(3, 'hB0, 2); wait_b();
    push_r('hB2, 0, 0, 1); push_r('hB2, 0, 1, 1);
    ar_hs(1, 'h20, 1, 2, 0); r_collect(1'b0);

    // Simultaneous AW/AR: write first, single-beat bursts
    push_mw(16, 'h55); push_b(2, 0); push_r('h55, 0, 1, 9);
    axi.awid = 4'd2; axi.awaddr = 16'h40; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = 2'd1; axi.awvalid = 1'b1;
    axi.arid = 4'd9; axi.araddr = 16'h40; axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = 2'd1; axi.arvalid = 1'b1;
    @(negedge clk);
    chk("simul_awready", 64'(axi.awready), 64'd1);
    chk("simul_arready", 64'(axi.arready), 64'd0);
    @(posedge clk); #1 axi.awvalid = 1'b0;
    @(negedge clk);
    chk("ar_blocked_in_write", 64'(axi.arready), 64'd0);
    @(posedge clk); #1;
    w_beats(1, 'h55, 0); wait_b();
    ar_hs(9, 'h40, 0, 2, 1); r_collect(1'b0);

    // Reserved burst type read
    for (int i = 0; i < 4; i++) push_r(0, 2, i == 3, 10);
    forbid_mem = 1'b1;
    ar_hs(10, 'h10, 3, 2, 3); r_collect(1'b0);
    forbid_mem = 1'b0;

    // Wrong size write
    push_b(11, 2);
    forbid_mem = 1'b1;
    aw_hs(11, 'h10, 1, 1, 1); w_beats(2, 'hEE, 1); wait_b();
    forbid_mem = 1'b0;

    // WRAP with illegal len 2
    for (int i = 0; i < 3; i++) push_r(0, 2, i == 2, 12);
    forbid_mem = 1'b1;
    ar_hs(12, 'h10, 2, 2, 2); r_collect(1'b0);
    forbid_mem = 1'b0;

    // wlast on the wrong beat: writes happen, response SLVERR
    push_mw(12, 'hD0); push_mw(13, 'hD1); push_b(13, 2);
    aw_hs(13, 'h30, 1, 2, 1); w_beats(2, 'hD0, 0); wait_b();

`ifdef AXI_MEM_BOUNDARY_CHECK_EN
    push_b(14, 2);
    forbid_mem = 1'b1;
    aw_hs(14, 'hFFC, 1, 2, 1); w_beats(2, 'hF0, 1); wait_b();
    forbid_mem = 1'b0;
`else
    push_mw('h3FF, 'hF0); push_mw(0, 'hF1); push_b(14, 0);
    aw_hs(14, 'hFFC, 1, 2, 1); w_beats(2, 'hF0, 1); wait_b();
`endif

    // Reset after 2 of 8 write beats
    push_mw(32, 'hC0); push_mw(33, 'hC1);
    aw_hs(1, 'h80, 7, 2, 1); w_beats(2, 'hC0, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wready", 64'(axi.wready), 64'd0);
    chk("midrst_awready", 64'(axi.awready), 64'd0);
    chk("midrst_mem_en", 64'(mem_en), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("after_rst_awready", 64'(axi.awready), 64'd1);
    chk("after_rst_wready", 64'(axi.wready), 64'd0);
    @(posedge clk); #1;
    push_mw(36, 'hC8); push_mw(37, 'hC9); push_b(2, 0);
    aw_hs(2, 'h90, 1, 2, 1); w_beats(2, 'hC8, 1); wait_b();
    push_r('hC0, 0, 0, 3); push_r('hC1, 0, 1, 3);
    ar_hs(3, 'h80, 1, 2, 1); r_collect(1'b0);

    repeat (3) @(posedge clk);
    chk("mem_writes_left", 64'(exp_mw.size()), 64'd0);
    chk("r_beats_left", 64'(exp_r.size()), 64'd0);
    chk("b_resps_left", 64'(exp_b.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
